strobed_sample_fifo: RTL
========================

# strobed_sample_fifo

Sample buffer between the upstream audio/sample source and the modulator datapath, paced by the strobe from the rate-strobe generator. Samples are written with a valid/ready handshake at the producer's rate. Exactly one sample is released per incoming strobe, so the downstream modulator receives a steady, programmable sample rate. Underflow behaviour is defined, so the modulator always has a sample to use.

## Interface
- WIDTH, 16, sample width in bits
- DEPTH_LOG2, 4, log2 of FIFO depth (depth = 2**DEPTH_LOG2)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of FIFO contents
- in_data  in  WIDTH  sample from producer
- in_valid  in  1  producer has a sample
- in_ready  out  1  FIFO can accept a sample this cycle
- stb  in  1  one-cycle rate strobe from the strober
- out_data  out  WIDTH  current sample to modulator, held between strobes
- out_stb  out  1  one-cycle pulse: out_data updated this cycle
- underflow  out  1  one-cycle pulse: stb arrived with FIFO empty
- level  out  DEPTH_LOG2+1  current occupancy, 0..depth

## Operation
- Storage: circular buffer of depth entries.
  - Write pointer and read pointer are DEPTH_LOG2+1 bits each; the extra MSB distinguishes full from empty.
  - level = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1).
- in_ready = (level != depth), combinational from registered pointers.
- Write: occurs when in_valid && in_ready; stores in_data at wr_ptr and increments wr_ptr. Pointers wrap naturally.
- Read: occurs when stb && level != 0.
  - out_data <= mem[rd_ptr]; rd_ptr increments; out_stb <= 1.
- stb with level == 0:
  - underflow <= 1 and out_stb <= 1.
  - out_data per Configuration.
- No bypass: a write and a stb in the same cycle with level == 0 count as underflow; the written sample is read at the next stb.
- Write and read in the same cycle with 0 < level < depth: both occur, level unchanged.
- At level == depth, in_ready is low, so no write occurs; a same-cycle read still occurs.
- flush: rd_ptr <= wr_ptr <= 0.
  - The in-flight write and stb of that cycle are ignored.
  - out_stb, underflow <= 0.
  - out_data is retained.
- Precedence: rst > flush > normal operation.
- Reset values:
  - pointers 0, level 0, in_ready 1
  - out_data 0, out_stb 0, underflow 0
- Reset mid-stream discards contents; the first post-reset stb with no prior write is an underflow.

## Timing
- Latency:
  - stb to out_stb/out_data/underflow: 1 cycle.
  - Write to level visible: 1 cycle.
  - Write to eligible for a read: next cycle.
- in_ready reflects the pointers registered at the start of the cycle; it deasserts the cycle after the write that fills the FIFO.
- Back-to-back stb (strober rate = 1) is supported: one read per cycle.
- out_data is stable between out_stb pulses.

## Configuration
- STROBED_FIFO_HOLD_LAST_EN:
  - Defined: on underflow, out_data holds its previous value (zero-order hold).
  - Undefined: on underflow, out_data <= 0 (silence).
- underflow and out_stb pulse identically in both builds.

## Structure
- The shared package fm_pkg holds:
  - default WIDTH (16) and DEPTH_LOG2 (4)
  - sample typedef/width constant, shared with the strober-rate and modulator blocks
- Sub-module sample_ram: simple dual-port register array.
  - One write port; combinational read at rd_ptr index.
  - Instantiated once.
  - Pointer and flag logic stays in the top module.

## Test plan
- After reset, write 0x0011, 0x0022, 0x0033 with no stb:
  - level = 3, in_ready = 1, out_data = 0, no out_stb.
- Then apply three stb one cycle apart:
  - out_stb on the cycle after each stb.
  - out_data = 0x0011, 0x0022, 0x0033 in order.
  - level returns to 0.
- Fill 16 entries (DEPTH_LOG2 = 4) with in_valid held:
  - in_ready = 0 with level = 16.
  - 17th sample not accepted.
  - One stb releases entry 0; in_ready = 1 next cycle; the 17th sample is then written.
- stb on empty FIFO after out_data = 0x0033:
  - underflow and out_stb pulse one cycle later.
  - out_data = 0x0033 with STROBED_FIFO_HOLD_LAST_EN defined, 0 without.
- Same-cycle write and stb at level 5: read and write both occur, level stays 5.
- Same-cycle write and stb at level 0: underflow, level becomes 1.
- flush at level 7, asserted together with in_valid and stb:
  - level = 0 next cycle.
  - No out_stb, no underflow.
  - out_data unchanged.
- 40 write/read pairs: pointer wrap-around preserves data order.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared constants for the FM sample path: default sample width, FIFO depth and sample type.
// Used by the strober-rate, FIFO and modulator blocks.
package fm_pkg;

    localparam int WIDTH_DEF      = 16;
    localparam int DEPTH_LOG2_DEF = 4;
    localparam int SAMPLE_W       = WIDTH_DEF;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port register array: one synchronous write port, one combinational read port.
// Holds FIFO storage only; pointer and flag logic lives in strobed_sample_fifo.
module sample_ram #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/strobed_sample_fifo.sv
// Sample FIFO releasing exactly one sample per rate strobe, with defined underflow output.
// Build option: STROBED_FIFO_HOLD_LAST_EN holds the last sample on underflow instead of silence.
module strobed_sample_fifo
    import fm_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  stb,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_stb,
    output logic                  underflow,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] DEPTH = PTR_W'(2**DEPTH_LOG2);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_stb_q, out_stb_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] rd_data;
    logic             wr_en;
    logic             not_empty;

    assign level     = wr_ptr_q - rd_ptr_q;
    assign in_ready  = (level != DEPTH);
    assign not_empty = (level != '0);
    assign wr_en     = in_valid && in_ready && !flush && !rst;

    sample_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata (rd_data)
    );

    // Read decision uses pre-write occupancy, so a same-cycle write into an empty FIFO is not bypassed.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_data_d  = out_data_q;
        out_stb_d   = 1'b0;
        underflow_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (stb) begin
                out_stb_d = 1'b1;
                if (not_empty) begin
                    out_data_d = rd_data;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                end else begin
                    underflow_d = 1'b1;
`ifdef STROBED_FIFO_HOLD_LAST_EN
                    out_data_d = out_data_q;
`else
                    out_data_d = '0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            out_stb_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_data_q  <= out_data_d;
            out_stb_q   <= out_stb_d;
            underflow_q <= underflow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_stb   = out_stb_q;
    assign underflow = underflow_q;

endmodule
